card_draw_arbiter: RTL and testbench

//  Shares one card RNG between N requesters, e.g. player and dealer hands. It

---
 rtl/card_draw_arbiter.sv | 159 +++++++++++++++
 tb/tb_card_draw_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_draw_arbiter.sv
// Round-robin arbiter sharing one card RNG between N_REQ requesters, with LFSR settle spacing and seed-load sequencing.
// Optional draw counter (draw_cnt port) is compiled in when CARD_DRAW_STATS_EN is defined.
module card_draw_arbiter #(
  parameter int          N_REQ         = 2,
  parameter int          SETTLE_CYCLES = 3,
  parameter logic [15:0] SEED_DEFAULT  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_req,
  input  logic [15:0]      seed_in,
  input  logic [4:0]       card_val,
  output logic             lfsr_load,
  output logic [15:0]      lfsr_seed,
  output logic [N_REQ-1:0] gnt,
  output logic [4:0]       card_out,
  output logic             card_vld,
  output logic             busy
`ifdef CARD_DRAW_STATS_EN
  ,
  output logic [15:0]      draw_cnt
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEED, SETTLE, DEAL} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [PW-1:0]    rr_ptr, rr_nxt;
  logic [PW-1:0]    owner, owner_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [4:0]       card_out_nxt;
  logic             card_vld_nxt;
  logic             load_nxt;
  logic [15:0]      seed_nxt;

  logic [PW-1:0]    pick;
  logic             pick_vld;
  int               idx;
  logic             card_ok;
  logic             owner_holds;

  // First set request at or after rr_ptr, scanning circularly.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && req[idx[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[PW-1:0];
      end
    end
  end

  assign card_ok     = (card_val >= 5'd2) && (card_val <= 5'd11);
  assign owner_holds = |(req & gnt);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    rr_nxt       = rr_ptr;
    owner_nxt    = owner;
    gnt_nxt      = gnt;
    card_out_nxt = card_out;
    card_vld_nxt = 1'b0;
    load_nxt     = lfsr_load;
    seed_nxt     = lfsr_seed;

    unique case (state)
      IDLE: begin
        if (seed_req) begin
          seed_nxt  = seed_in;
          load_nxt  = 1'b1;
          state_nxt = SEED;
        end else if (pick_vld) begin
          gnt_nxt   = N_REQ'(1) << pick;
          owner_nxt = pick;
          cnt_nxt   = CNT_INIT;
          state_nxt = SETTLE;
        end
      end
      SEED: begin
        load_nxt  = 1'b0;
        seed_nxt  = SEED_DEFAULT;
        gnt_nxt   = '0;
        cnt_nxt   = CNT_INIT;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (gnt == '0) begin
          // Settle after a seed load: no owner, just burn the shifts.
          if (cnt != '0) cnt_nxt = cnt - 1'b1;
          else           state_nxt = IDLE;
        end else if (!owner_holds) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (card_ok) begin
          card_out_nxt = card_val;
          card_vld_nxt = 1'b1;
          state_nxt    = DEAL;
        end
      end
      DEAL: begin
        gnt_nxt   = '0;
        rr_nxt    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      gnt       <= '0;
      card_out  <= '0;
      card_vld  <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_seed <= SEED_DEFAULT;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      gnt       <= gnt_nxt;
      card_out  <= card_out_nxt;
      card_vld  <= card_vld_nxt;
      lfsr_load <= load_nxt;
      lfsr_seed <= seed_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef CARD_DRAW_STATS_EN
  // Counts delivered cards only; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               draw_cnt <= '0;
    else if (card_vld_nxt) draw_cnt <= draw_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Self-checking bench for card_draw_arbiter: directed scenarios plus randomized requesters,
// all compared every cycle against a transaction-timing reference model.
module tb_card_draw_arbiter;

  localparam int          N_REQ  = 2;
  localparam int          SETTLE = 3;
  localparam logic [15:0] SEED_D = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             seed_req;
  logic [15:0]      seed_in;
  logic [4:0]       card_val;
  logic             lfsr_load;
  logic [15:0]      lfsr_seed;
  logic [N_REQ-1:0] gnt;
  logic [4:0]       card_out;
  logic             card_vld;
  logic             busy;
`ifdef CARD_DRAW_STATS_EN
  logic [15:0]      draw_cnt;
`endif

  card_draw_arbiter #(.N_REQ(N_REQ), .SETTLE_CYCLES(SETTLE), .SEED_DEFAULT(SEED_D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_req  (seed_req),
    .seed_in   (seed_in),
    .card_val  (card_val),
    .lfsr_load (lfsr_load),
    .lfsr_seed (lfsr_seed),
    .gnt       (gnt),
    .card_out  (card_out),
    .card_vld  (card_vld),
    .busy      (busy)
`ifdef CARD_DRAW_STATS_EN
    ,
    .draw_cnt  (draw_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: tracks the transaction in progress and the edge it started on;
  // a draw may deliver once SETTLE edges have elapsed since the grant.
  localparam int M_IDLE = 0, M_LOAD = 1, M_SWAIT = 2, M_DRAW = 3, M_DEALT = 4;
  int               m_mode, m_owner, m_next, m_t0, cyc;
  logic [N_REQ-1:0] m_gnt;
  logic             m_vld, m_load, m_busy;
  logic [15:0]      m_seed, m_draws;
  logic [4:0]       m_card;

  task automatic model_reset();
    m_mode = M_IDLE; m_owner = 0; m_next = 0; m_t0 = 0;
    m_gnt = '0; m_vld = 1'b0; m_load = 1'b0; m_busy = 1'b0;
    m_seed = SEED_D; m_draws = '0; m_card = '0;
  endtask

  task automatic model_step();
    bit found;
    cyc++;
    m_vld = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (seed_req) begin
          m_mode = M_LOAD; m_load = 1'b1; m_seed = seed_in;
        end else if (req != '0) begin
          found = 0;
          for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_next + k) % N_REQ;
            if (!found && req[c]) begin found = 1; m_owner = c; end
          end
          m_gnt  = '0;
          m_gnt[m_owner] = 1'b1;
          m_t0   = cyc;
          m_mode = M_DRAW;
        end
      end
      M_LOAD: begin
        m_load = 1'b0; m_seed = SEED_D; m_t0 = cyc; m_mode = M_SWAIT;
      end
      M_SWAIT: if (cyc - m_t0 >= SETTLE) m_mode = M_IDLE;
      M_DRAW: begin
        if (!req[m_owner]) begin
          m_gnt = '0; m_mode = M_IDLE;
        end else if (cyc - m_t0 >= SETTLE && card_val >= 2 && card_val <= 11) begin
          m_card = card_val; m_vld = 1'b1; m_draws = m_draws + 16'd1; m_mode = M_DEALT;
        end
      end
      M_DEALT: begin
        m_gnt = '0; m_next = (m_owner + 1) % N_REQ; m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    m_busy = (m_mode != M_IDLE);
  endtask

  task automatic compare_all();
    check("gnt",       gnt,       m_gnt);
    check("card_vld",  card_vld,  m_vld);
    check("card_out",  card_out,  m_card);
    check("busy",      busy,      m_busy);
    check("lfsr_load", lfsr_load, m_load);
    check("lfsr_seed", lfsr_seed, m_seed);
`ifdef CARD_DRAW_STATS_EN
    check("draw_cnt",  draw_cnt,  m_draws);
`endif
  endtask

  // One clock: inputs already set; update model at the edge, compare mid-cycle.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Keep stepping until the current owner gets its card, then release its request.
  task automatic finish_draw(input string tag);
    bit got;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      if (card_vld) begin got = 1; req = req & ~gnt; end
    end
    check(tag, 32'(got), 32'd1);
  endtask

  int   served;
  int   order [2];
  logic [15:0] draws_before;

  initial begin
    rst = 1'b1; req = '0; seed_req = 1'b0; seed_in = '0; card_val = 5'd7;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_seed", lfsr_seed, 16'hACE1);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt",  gnt, 2'b00);
    check("rst_vld",  card_vld, 1'b0);
    check("rst_load", lfsr_load, 1'b0);
    check("rst_card", card_out, 5'd0);
    rst = 1'b0;

    // Single draw: card lands exactly SETTLE edges after the grant.
    req = 2'b01; card_val = 5'd7;
    step(); check("t2_gnt", gnt, 2'b01);
    step(); check("t2_vld_early1", card_vld, 1'b0);
    step(); check("t2_vld_early2", card_vld, 1'b0);
    step(); check("t2_vld", card_vld, 1'b1); check("t2_card", card_out, 5'd7);
    req = 2'b00;
    step(); check("t2_vld_pulse", card_vld, 1'b0); check("t2_idle", busy, 1'b0);

    // Illegal card at settle end forces resample; rr_ptr now points at requester 1.
    req = 2'b10; card_val = 5'd15;
    step(); check("t5_gnt", gnt, 2'b10);
    step(); step();
    step(); check("t5_no_vld", card_vld, 1'b0); check("t5_busy", busy, 1'b1);
    card_val = 5'd11;
    step(); check("t5_vld", card_vld, 1'b1); check("t5_card", card_out, 5'd11);
    req = 2'b00;
    step();

    // Both requesting: served 01 then 10, each releasing after its own card.
    req = 2'b11; card_val = 5'd7; served = 0; order[0] = 0; order[1] = 0;
    for (int t = 0; t < 40 && served < 2; t++) begin
      step();
      if (card_vld) begin
        order[served] = int'(gnt);
        req = req & ~gnt;
        served++;
      end
    end
    check("t3_served", served, 2);
    check("t3_first",  order[0], 1);
    check("t3_second", order[1], 2);
    step(); check("t3_idle", busy, 1'b0);
    req = 2'b11;
    step(); check("t3_rotation", gnt, 2'b01);

    // Abort mid-settle: back to idle, no card, pointer not advanced.
`ifdef CARD_DRAW_STATS_EN
    draws_before = draw_cnt;
`else
    draws_before = '0;
`endif
    req = 2'b00;
    step(); check("t6_no_vld", card_vld, 1'b0); check("t6_idle", busy, 1'b0);
`ifdef CARD_DRAW_STATS_EN
    check("t6_draw_cnt", draw_cnt, draws_before);
`endif
    req = 2'b11;
    step(); check("t6_rr_kept", gnt, 2'b01);
    finish_draw("t6_draw0");
    finish_draw("t6_draw1");
    req = 2'b00;
    step();

    // Seed request wins over a simultaneous card request.
    seed_req = 1'b1; seed_in = 16'h1234; req = 2'b01;
    step(); check("t4_load", lfsr_load, 1'b1); check("t4_seed", lfsr_seed, 16'h1234);
    check("t4_no_gnt", gnt, 2'b00);
    seed_req = 1'b0; seed_in = 16'h0;
    step(); check("t4_load_drop", lfsr_load, 1'b0); check("t4_seed_def", lfsr_seed, 16'hACE1);
    step(); check("t4_settle_a", busy, 1'b1);
    step(); check("t4_settle_b", busy, 1'b1);
    step(); check("t4_idle", busy, 1'b0); check("t4_gnt_wait", gnt, 2'b00);
    step(); check("t4_gnt", gnt, 2'b01);
    finish_draw("t4_draw");
    req = 2'b00;
    step();

    // Reset in the middle of a seed load takes effect without a clock edge.
    seed_req = 1'b1; seed_in = 16'hBEEF;
    step(); check("rmid_load", lfsr_load, 1'b1);
    seed_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rmid_load_drop", lfsr_load, 1'b0);
    check("rmid_seed", lfsr_seed, 16'hACE1);
    check("rmid_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized requesters, seed pulses and card values.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if ((card_vld && gnt[i]) || $urandom_range(0, 49) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      seed_req = ($urandom_range(0, 19) == 0);
      seed_in  = 16'($urandom);
      card_val = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(2, 11));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
